// File: rtl/fetch_stage_if.sv
// fetch_stage_if: request/response handshake between the fetch stage (master)
// and instruction memory (slave).
interface fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;
  logic            rready;

  modport master (
    output req, addr, rready,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, rready,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, single-outstanding imem handshake and IF/ID register.
// Define FETCH_SKID_EN to add a one-entry skid buffer behind IF/ID.
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirectPc,
  fetch_stage_if.master   imem,
  output logic            o_idValid,
  output logic [XLEN-1:0] o_idInstr,
  output logic [XLEN-1:0] o_idPc,
  output logic [XLEN-1:0] o_idPcPlus4
);

  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetchState_t;

  fetchState_t     r_state;
  fetchState_t     w_nextState;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_nextPc;
  logic [XLEN-1:0] r_reqPc;
  logic [XLEN-1:0] w_redirectTarget;
  logic            w_slotFree;
  logic            w_rreadyBase;
  logic            w_granted;
  logic            w_rvFire;
  logic            w_accept;
  logic            w_srcValid;
  logic [XLEN-1:0] w_srcInstr;
  logic [XLEN-1:0] w_srcPc;

  assign w_redirectTarget = i_redirectPc & ~{{(XLEN-2){1'b0}}, 2'b11};

`ifdef FETCH_SKID_EN
  logic            r_skidValid;
  logic [XLEN-1:0] r_skidInstr;
  logic [XLEN-1:0] r_skidPc;

  // A slot exists as long as either IF/ID or the skid entry can take a response.
  assign w_slotFree   = !o_idValid || !i_stall || !r_skidValid;
  assign w_rreadyBase = !r_skidValid;
  assign w_srcValid   = r_skidValid || w_accept;
  assign w_srcInstr   = r_skidValid ? r_skidInstr : imem.rdata;
  assign w_srcPc      = r_skidValid ? r_skidPc : r_reqPc;
`else
  assign w_slotFree   = !o_idValid || !i_stall;
  assign w_rreadyBase = w_slotFree;
  assign w_srcValid   = w_accept;
  assign w_srcInstr   = imem.rdata;
  assign w_srcPc      = r_reqPc;
`endif

  // Requests are withheld while nothing could absorb the response.
  assign imem.req    = (r_state == REQ) && w_slotFree;
  assign imem.addr   = r_pc;
  assign imem.rready = (r_state == DROP) ||
                       ((r_state == WAIT) && (w_rreadyBase || i_redirect));

  assign w_granted = imem.req && imem.gnt;
  assign w_rvFire  = imem.rvalid && imem.rready;
  assign w_accept  = (r_state == WAIT) && w_rvFire && !i_redirect;

  always_comb begin
    w_nextState = r_state;
    w_nextPc    = r_pc;
    case (r_state)
      IDLE: begin
        if (w_slotFree || i_redirect) begin
          w_nextState = REQ;
        end
      end
      REQ: begin
        if (w_granted) begin
          w_nextState = WAIT;
          w_nextPc    = r_pc + XLEN'(4);
        end
      end
      WAIT: begin
        if (w_rvFire) begin
          w_nextState = (w_slotFree || i_redirect) ? REQ : IDLE;
        end else if (i_redirect) begin
          w_nextState = DROP;
        end
      end
      DROP: begin
        if (w_rvFire) begin
          w_nextState = REQ;
        end
      end
      default: w_nextState = IDLE;
    endcase

    // A request granted in the redirect cycle still owes us a response to discard.
    if (i_redirect) begin
      w_nextPc = w_redirectTarget;
      if ((r_state == REQ) && w_granted) begin
        w_nextState = DROP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_reqPc <= RESET_PC;
    end else begin
      r_state <= w_nextState;
      r_pc    <= w_nextPc;
      if (w_granted) begin
        r_reqPc <= r_pc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_idValid   <= 1'b0;
      o_idInstr   <= NOP_INSTR;
      o_idPc      <= '0;
      o_idPcPlus4 <= '0;
    end else if (i_redirect) begin
      o_idValid <= 1'b0;
    end else if (!o_idValid || !i_stall) begin
      o_idValid <= w_srcValid;
      if (w_srcValid) begin
        o_idInstr   <= w_srcInstr;
        o_idPc      <= w_srcPc;
        o_idPcPlus4 <= w_srcPc + XLEN'(4);
      end
    end
  end

`ifdef FETCH_SKID_EN
  // The skid only fills when IF/ID is full and held; it drains whenever decode advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skidValid <= 1'b0;
      r_skidInstr <= NOP_INSTR;
      r_skidPc    <= '0;
    end else if (i_redirect) begin
      r_skidValid <= 1'b0;
    end else if (w_accept && o_idValid && i_stall) begin
      r_skidValid <= 1'b1;
      r_skidInstr <= imem.rdata;
      r_skidPc    <= r_reqPc;
    end else if (!i_stall) begin
      r_skidValid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed tests of fetch_stage against a small instruction
// memory model that returns addr + 0x100 as the instruction word.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        idValid;
  logic [31:0] idInstr;
  logic [31:0] idPc;
  logic [31:0] idPcPlus4;

  int checks = 0;
  int errors = 0;

`ifdef FETCH_SKID_EN
  localparam int STALL_GRANTS = 1;
  localparam int UNSTALL_LAT  = 1;
`else
  localparam int STALL_GRANTS = 0;
  localparam int UNSTALL_LAT  = 2;
`endif

  always #5 clk = ~clk;

  fetch_stage_if #(.XLEN(32)) imem ();

  fetch_stage #(
    .XLEN(32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_stall(stall),
    .i_redirect(redirect),
    .i_redirectPc(redirectPc),
    .imem(imem),
    .o_idValid(idValid),
    .o_idInstr(idInstr),
    .o_idPc(idPc),
    .o_idPcPlus4(idPcPlus4)
  );

  // Memory model: gnt after memGntDelay waiting cycles, rvalid memRvDelay cycles
  // after the grant, response held until rready.
  int          memGntDelay = 0;
  int          memRvDelay  = 0;
  int          memGntWait;
  int          memRvWait;
  int          grantCount  = 0;
  logic        memPending;
  logic [31:0] memAddr;

  assign imem.gnt    = imem.req && (memGntWait == 0);
  assign imem.rvalid = memPending && (memRvWait == 0);
  assign imem.rdata  = memAddr + 32'h100;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      memPending <= 1'b0;
      memAddr    <= '0;
      memRvWait  <= 0;
      memGntWait <= memGntDelay;
    end else begin
      if (imem.rvalid && imem.rready) begin
        memPending <= 1'b0;
      end else if (memPending && memRvWait != 0) begin
        memRvWait <= memRvWait - 1;
      end
      if (imem.req && imem.gnt) begin
        memPending <= 1'b1;
        memAddr    <= imem.addr;
        memRvWait  <= memRvDelay;
        memGntWait <= memGntDelay;
        grantCount <= grantCount + 1;
      end else if (imem.req && memGntWait != 0) begin
        memGntWait <= memGntWait - 1;
      end
    end
  end

  // Holds reset for two cycles and releases it on a falling edge.
  task doReset;
    rst        = 1'b1;
    stall      = 1'b0;
    redirect   = 1'b0;
    redirectPc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task test_reset;
    rst        = 1'b1;
    stall      = 1'b0;
    redirect   = 1'b0;
    redirectPc = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (imem.req !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_req got %0b want 0", imem.req);
    end
    checks++;
    if (imem.addr !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_addr got %h want 00000000", imem.addr);
    end
    checks++;
    if (idValid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid got %0b want 0", idValid);
    end
    checks++;
    if (idInstr !== 32'h0000_0013) begin
      errors++; $display("[TB] FAIL reset_instr got %h want 00000013", idInstr);
    end
    checks++;
    if (idPc !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_pc got %h want 00000000", idPc);
    end
    checks++;
    if (idPcPlus4 !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_pc4 got %h want 00000000", idPcPlus4);
    end
  endtask

  // Zero-wait memory: first valid 3 cycles after release, then one every 2 cycles.
  task test_zero_wait;
    logic [31:0] expPc;
    memGntDelay = 0;
    memRvDelay  = 0;
    doReset();
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 2) begin
        checks++;
        if (idValid !== 1'b0) begin
          errors++; $display("[TB] FAIL zw_early_valid got %0b want 0", idValid);
        end
      end
      if (k == 3 || k == 5 || k == 7) begin
        expPc = 32'((k - 3) * 2);
        checks++;
        if ({idValid, idPc, idInstr, idPcPlus4} !== {1'b1, expPc, expPc + 32'h100, expPc + 32'h4}) begin
          errors++;
          $display("[TB] FAIL zw_fetch got v=%0b pc=%h instr=%h pc4=%h want v=1 pc=%h instr=%h pc4=%h",
                   idValid, idPc, idInstr, idPcPlus4, expPc, expPc + 32'h100, expPc + 32'h4);
        end
      end
    end
  endtask

  // Continues from test_zero_wait with IF/ID holding pc 0x8.
  task test_stall;
    int g0;
    stall = 1'b1;
    g0    = grantCount;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({idValid, idPc, idInstr, idPcPlus4} !== {1'b1, 32'h8, 32'h108, 32'hC}) begin
        errors++;
        $display("[TB] FAIL stall_hold got v=%0b pc=%h instr=%h pc4=%h want v=1 pc=00000008 instr=00000108 pc4=0000000c",
                 idValid, idPc, idInstr, idPcPlus4);
      end
    end
    checks++;
    if (grantCount - g0 !== STALL_GRANTS) begin
      errors++; $display("[TB] FAIL stall_grants got %0d want %0d", grantCount - g0, STALL_GRANTS);
    end
    stall = 1'b0;
    repeat (UNSTALL_LAT) @(negedge clk);
    checks++;
    if ({idValid, idPc, idInstr} !== {1'b1, 32'hC, 32'h10C}) begin
      errors++;
      $display("[TB] FAIL unstall_next got v=%0b pc=%h instr=%h want v=1 pc=0000000c instr=0000010c",
               idValid, idPc, idInstr);
    end
  endtask

  task test_gnt_delay;
    bit found;
    int g0;
    memGntDelay = 3;
    memRvDelay  = 0;
    doReset();
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (imem.req && imem.addr == 32'h4) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("[TB] FAIL gnt_req4_seen got 0 want 1");
    end
    g0 = grantCount;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if ({imem.req, imem.gnt, imem.addr} !== {1'b1, (k == 3), 32'h4}) begin
        errors++;
        $display("[TB] FAIL gnt_hold cycle %0d got req=%0b gnt=%0b addr=%h want req=1 gnt=%0b addr=00000004",
                 k, imem.req, imem.gnt, imem.addr, (k == 3));
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (grantCount - g0 !== 1) begin
      errors++; $display("[TB] FAIL gnt_single got %0d want 1", grantCount - g0);
    end
    memGntDelay = 0;
  endtask

  // Slow responses so the redirect lands in WAIT and the old response is dropped later.
  task test_redirect;
    bit found;
    bit got;
    memGntDelay = 0;
    memRvDelay  = 2;
    doReset();
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (memPending && memAddr == 32'h10 && !imem.rvalid) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("[TB] FAIL redir_wait10_seen got 0 want 1");
    end
    redirect   = 1'b1;
    redirectPc = 32'h0000_0202;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if ({imem.req, imem.addr, idValid} !== {1'b0, 32'h200, 1'b0}) begin
      errors++;
      $display("[TB] FAIL redir_drop got req=%0b addr=%h v=%0b want req=0 addr=00000200 v=0",
               imem.req, imem.addr, idValid);
    end
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (idValid) got = 1'b1;
    end
    checks++;
    if (!got || {idPc, idInstr, idPcPlus4} !== {32'h200, 32'h300, 32'h204}) begin
      errors++;
      $display("[TB] FAIL redir_first got seen=%0b pc=%h instr=%h pc4=%h want seen=1 pc=00000200 instr=00000300 pc4=00000204",
               got, idPc, idInstr, idPcPlus4);
    end
    memRvDelay = 0;
  endtask

  task test_redirect_stall;
    bit got;
    doReset();
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (idValid) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++; $display("[TB] FAIL rs_first_valid got 0 want 1");
    end
    stall      = 1'b1;
    redirect   = 1'b1;
    redirectPc = 32'h0000_0300;
    @(negedge clk);
    stall    = 1'b0;
    redirect = 1'b0;
    checks++;
    if (idValid !== 1'b0) begin
      errors++; $display("[TB] FAIL rs_flush got v=%0b want 0", idValid);
    end
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (idValid) got = 1'b1;
    end
    checks++;
    if (!got || {idPc, idInstr, idPcPlus4} !== {32'h300, 32'h400, 32'h304}) begin
      errors++;
      $display("[TB] FAIL rs_target got seen=%0b pc=%h instr=%h pc4=%h want seen=1 pc=00000300 instr=00000400 pc4=00000304",
               got, idPc, idInstr, idPcPlus4);
    end
  endtask

  task test_reset_wait;
    bit found;
    bit got;
    doReset();
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (memPending && memAddr == 32'h8) found = 1'b1;
    end
    checks++;
    if (!found || {idPc, idInstr, imem.addr} !== {32'h4, 32'h104, 32'hC}) begin
      errors++;
      $display("[TB] FAIL rw_before got seen=%0b pc=%h instr=%h addr=%h want seen=1 pc=00000004 instr=00000104 addr=0000000c",
               found, idPc, idInstr, imem.addr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({imem.req, imem.addr, idValid, idInstr, idPc, idPcPlus4} !==
        {1'b0, 32'h0, 1'b0, 32'h13, 32'h0, 32'h0}) begin
      errors++;
      $display("[TB] FAIL rw_async got req=%0b addr=%h v=%0b instr=%h pc=%h pc4=%h want req=0 addr=0 v=0 instr=00000013 pc=0 pc4=0",
               imem.req, imem.addr, idValid, idInstr, idPc, idPcPlus4);
    end
    @(negedge clk);
    rst = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (imem.req) got = 1'b1;
    end
    checks++;
    if (!got || imem.addr !== 32'h0) begin
      errors++; $display("[TB] FAIL rw_first_req got seen=%0b addr=%h want seen=1 addr=00000000", got, imem.addr);
    end
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (idValid) got = 1'b1;
    end
    checks++;
    if (!got || {idPc, idInstr} !== {32'h0, 32'h100}) begin
      errors++;
      $display("[TB] FAIL rw_first_fetch got seen=%0b pc=%h instr=%h want seen=1 pc=00000000 instr=00000100",
               got, idPc, idInstr);
    end
  endtask

  initial begin
    rst        = 1'b1;
    stall      = 1'b0;
    redirect   = 1'b0;
    redirectPc = '0;
    test_reset();
    test_zero_wait();
    test_stall();
    test_gnt_delay();
    test_redirect();
    test_redirect_stall();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of decode.
- Holds the PC and runs a single-outstanding request/response handshake to instruction memory.
- Delivers instruction, PC and PC+4 through the IF/ID pipeline register that decode consumes.
- Honours stall from the hazard logic and redirect from execute (taken branch/jump).

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- XLEN, 32, address/data width; only 32 is supported.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- stall_i  in  1  decode does not consume IF/ID this cycle.
- redirect_i  in  1  execute redirect; flushes fetch and IF/ID.
- redirect_pc_i  in  32  redirect target.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  32  request address (word aligned).
- imem_gnt_i  in  1  memory accepts request this cycle.
- imem_rvalid_i  in  1  response valid.
- imem_rdata_i  in  32  response instruction.
- imem_rready_o  out  1  fetch can accept a response this cycle.
- id_valid_o  out  1  IF/ID holds a valid instruction.
- id_instr_o  out  32  instruction to decode.
- id_pc_o  out  32  PC of id_instr_o.
- id_pc_plus4_o  out  32  id_pc_o + 4, used for the jal/jalr link.

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, state=IDLE. Outputs: imem_req_o=0, imem_addr_o=RESET_PC, id_valid_o=0, id_instr_o=32'h0000_0013 (nop), id_pc_o=0, id_pc_plus4_o=0. Skid buffer is empty. Reset asserted mid-request abandons the request; memory is reset by the same rst.
- States:
  - IDLE: no request outstanding.
  - REQ: imem_req_o=1, waiting for gnt.
  - WAIT: granted, waiting for rvalid.
  - DROP: granted, but a redirect occurred; the response is discarded.
- IDLE -> REQ: next cycle after reset, and whenever a slot is free.
- REQ:
  - imem_addr_o=pc, held stable until gnt.
  - gnt: -> WAIT, pc <= pc+4 (32-bit wrap, FFFF_FFFC -> 0000_0000).
- WAIT, rvalid && rready: instruction is accepted, tagged with its request address; -> REQ if a slot remains free, else IDLE.
- Slot free means: IF/ID empty, or IF/ID consumed this cycle (!stall_i), or skid empty (feature on).
- Acceptance: imem_rready_o = !id_valid_o || !stall_i (feature off). Memory must hold rvalid/rdata until rready.
- IF/ID update per cycle, in priority order:
  - redirect_i: id_valid_o <= 0.
  - !stall_i: load the accepted response (or skid) if present, else id_valid_o <= 0.
  - stall_i: hold all id_* outputs unchanged.
- Redirect (any state):
  - pc <= redirect_pc_i; IF/ID and skid are cleared.
  - In REQ without gnt in the same cycle: the request is dropped and re-issued next cycle at redirect_pc_i (address may change only on redirect).
  - In REQ with gnt in the same cycle, or in WAIT: -> DROP. Assert rready in DROP; on rvalid discard the data -> REQ.
  - In IDLE: -> REQ.
- Simultaneous redirect_i and stall_i: redirect wins.
- Simultaneous redirect and rvalid in WAIT: the response is discarded, -> REQ at redirect_pc_i.
- Latency: gnt and rvalid in the cycle following the request give one instruction every 2 cycles. A zero-wait memory (rvalid in the cycle after gnt) yields IF/ID valid 3 cycles after reset deassertion.
- Misaligned redirect_pc_i: bits [1:0] are forced to 0.

Optional Feature:
- Macro FETCH_SKID_EN.
- Defined:
  - Adds a one-entry skid buffer (instr + pc) and sets imem_rready_o = skid empty.
  - A response arriving while IF/ID is full and stalled goes to skid.
  - On unstall, skid moves to IF/ID the same cycle and a new request may issue.
  - Redirect clears skid.
- Undefined: no skid; rready as given in Behaviour; no request issues while IF/ID is full and stall_i=1.

Test Plan:
- Reset release, zero-wait memory returning addr+0x100 as data -> id_pc_o sequence 0,4,8 with id_instr_o 0x100,0x104,0x108; id_pc_plus4_o = id_pc_o+4.
- gnt delayed 3 cycles -> imem_addr_o stays 0x4 throughout REQ; a single request is granted.
- stall_i=1 for 4 cycles with IF/ID holding pc 0x8 -> id_* unchanged.
  - Feature off: no new grant.
  - FETCH_SKID_EN: exactly one response captured; on unstall, pc 0xC appears the next cycle.
- redirect_i with redirect_pc_i=0x200 while in WAIT for 0x10 -> 0x10 data never reaches IF/ID; next id_pc_o=0x200.
- redirect_i and stall_i in the same cycle with IF/ID valid -> id_valid_o=0 next cycle; fetch resumes at the target.
- Reset asserted during WAIT -> outputs return to reset values asynchronously; the first fetch after release is RESET_PC.
